// File: rtl/riscv_pkg.sv
// Constants and types shared by the RV32 load/store path: funct3 encodings,
// response codes, the LSU state enum and the legality/alignment check.
package riscv_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_t;

    // Illegal encodings win over misalignment; a clean request returns ERR_OK.
    function automatic logic [1:0] lsu_check(input logic       rd,
                                             input logic       wr,
                                             input logic [2:0] f3,
                                             input logic [1:0] lane);
        logic illegal;
        logic misaligned;
        illegal = 1'b0;
        if (rd == wr) begin
            illegal = 1'b1;
        end else if (rd) begin
            illegal = !(f3 == F3_B || f3 == F3_H || f3 == F3_W ||
                        f3 == F3_BU || f3 == F3_HU);
        end else begin
            illegal = !(f3 == F3_B || f3 == F3_H || f3 == F3_W);
        end
        misaligned = ((f3[1:0] == 2'b01) && lane[0]) ||
                     ((f3[1:0] == 2'b10) && (lane != 2'b00));
        if (illegal) begin
            return ERR_ILLEGAL;
        end else if (misaligned) begin
            return ERR_MISALIGN;
        end
        return ERR_OK;
    endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/halfword out of a read word and sign- or
// zero-extends it to 32 bits; words pass through untouched.
module load_align
    import riscv_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_lane,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [31:0] w_shift;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_shift = i_rdata >> {i_lane, 3'b000};
        w_byte  = w_shift[7:0];
        w_half  = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_funct3)
            F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_data = {24'b0, w_byte};
            F3_H:    o_data = {{16{w_half[15]}}, w_half};
            F3_HU:   o_data = {16'b0, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding RV32 load/store responder: checks a request, runs one
// word-wide bus access (or skips it on error) and returns one response strobe.
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int XLEN    = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic [1:0]      rsp_err,
    output logic            bus_req,
    output logic            bus_we,
    output logic [XLEN-1:0] bus_addr,
    output logic [XLEN-1:0] bus_wdata,
    output logic [3:0]      bus_be,
    input  logic            bus_ack,
    input  logic [XLEN-1:0] bus_rdata
);

    localparam int unsigned TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    lsu_state_t      r_state;
    logic            r_we;
    logic [2:0]      r_funct3;
    logic [1:0]      r_lane;
    logic [31:0]     r_cnt;
    logic            r_rsp_valid;
    logic [XLEN-1:0] r_rsp_rdata;
    logic [1:0]      r_rsp_err;
    logic            r_bus_req;
    logic            r_bus_we;
    logic [XLEN-1:0] r_bus_addr;
    logic [XLEN-1:0] r_bus_wdata;
    logic [3:0]      r_bus_be;

    logic [1:0]      w_err;
    logic [3:0]      w_be;
    logic [XLEN-1:0] w_wdata;
    logic [XLEN-1:0] w_ext;
    logic            w_timeout;

    assign w_err     = lsu_check(mem_read, mem_write, funct3, addr[1:0]);
    assign w_wdata   = wdata << {addr[1:0], 3'b000};
    assign w_timeout = (TIMEOUT != 0) && (r_cnt == TO_LAST);

    always_comb begin
        case (funct3[1:0])
            2'b00:   w_be = 4'b0001 << addr[1:0];
            2'b01:   w_be = 4'b0011 << addr[1:0];
            default: w_be = 4'b1111;
        endcase
    end

    load_align u_load_align (
        .i_rdata  (bus_rdata),
        .i_lane   (r_lane),
        .i_funct3 (r_funct3),
        .o_data   (w_ext)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_we        <= 1'b0;
            r_funct3    <= 3'b000;
            r_lane      <= 2'b00;
            r_cnt       <= 32'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= ERR_OK;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_be    <= 4'b0000;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_we     <= mem_write;
                        r_funct3 <= funct3;
                        r_lane   <= addr[1:0];
                        r_cnt    <= 32'd0;
                        if (w_err != ERR_OK) begin
                            r_state     <= ST_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= w_err;
                            r_rsp_rdata <= '0;
                        end else begin
                            r_state     <= ST_BUS;
                            r_bus_req   <= 1'b1;
                            r_bus_we    <= mem_write;
                            r_bus_addr  <= {addr[XLEN-1:2], 2'b00};
                            r_bus_wdata <= w_wdata;
                            r_bus_be    <= w_be;
                        end
                    end
                end
                ST_BUS: begin
                    // Ack and the last timeout cycle coincide: the ack wins.
                    if (bus_ack) begin
                        r_state     <= ST_RESP;
                        r_bus_req   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= ERR_OK;
                        r_rsp_rdata <= r_we ? '0 : w_ext;
                    end else if (w_timeout) begin
                        r_state     <= ST_RESP;
                        r_bus_req   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= ERR_TIMEOUT;
                        r_rsp_rdata <= '0;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                ST_RESP: begin
                    r_state     <= ST_IDLE;
                    r_rsp_err   <= ERR_OK;
                    r_rsp_rdata <= '0;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_bus_req <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = (r_state == ST_IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign bus_req   = r_bus_req;
    assign bus_we    = r_bus_we;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;
    assign bus_be    = r_bus_be;

endmodule
